inst_fetch: RTL and testbench

Instruction-fetch stage of the five-stage pipeline CPU: owns the program counter, issues word requests to instruction memory and delivers each fetched 32-bit instruction with its PC+4 into the IF/ID pipeline register consumed by the decode/control logic. It honours stalls from the hazard unit and redirects (taken branch/jump) from the EX stage, squashing wrong-path fetches with NOP bubbles.

---
 rtl/inst_fetch_pkg.sv | 22 ++
 rtl/inst_fetch_if.sv | 24 ++
 rtl/inst_fetch_skid_buffer.sv | 38 +++
 rtl/inst_fetch.sv | 107 ++++++++++
 tb/tb_inst_fetch.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: reset PC, bubble word,
// FSM encodings and PC arithmetic helpers.
package inst_fetch_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        IF_BOOT = 2'd0,
        IF_RUN  = 2'd1,
        IF_HELD = 2'd2
    } if_state_e;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: hazard/EX controls, instruction memory handshake and the
// IF/ID pipeline register outputs. master = fetch stage, slave = environment.
interface inst_fetch_if;
    logic        Stall;
    logic        Redirect;
    logic [31:0] Redirect_PC;
    logic        IMem_Req;
    logic [31:0] IMem_Addr;
    logic        IMem_Ready;
    logic [31:0] IMem_Data;
    logic [31:0] IF_ID_Inst;
    logic [31:0] IF_ID_PC4;
    logic        IF_ID_Valid;

    modport master (
        input  Stall, Redirect, Redirect_PC, IMem_Ready, IMem_Data,
        output IMem_Req, IMem_Addr, IF_ID_Inst, IF_ID_PC4, IF_ID_Valid
    );

    modport slave (
        output Stall, Redirect, Redirect_PC, IMem_Ready, IMem_Data,
        input  IMem_Req, IMem_Addr, IF_ID_Inst, IF_ID_PC4, IF_ID_Valid
    );
endinterface

// File: rtl/inst_fetch_skid_buffer.sv
// One-entry fetch skid buffer (instruction + PC+4) with load, drain and clear;
// clear wins over load, load wins over drain.
module inst_fetch_skid_buffer (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_drain,
    input  logic        i_clear,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc4,
    output logic        o_full,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc4
);
    logic        r_full;
    logic [31:0] r_inst;
    logic [31:0] r_pc4;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_full <= 1'b0;
            r_inst <= 32'h0;
            r_pc4  <= 32'h0;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_inst <= i_inst;
            r_pc4  <= i_pc4;
        end else if (i_drain) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_inst = r_inst;
    assign o_pc4  = r_pc4;
endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC, memory request and IF/ID register with stall,
// redirect and bubble insertion. Define IF_SKID_BUFFER_EN to fetch through stalls.
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    inst_fetch_if.master bus
);
    // state   | meaning
    // IF_BOOT | one idle cycle after reset release, no request
    // IF_RUN  | fetching at r_pc
    // IF_HELD | skid holds a word fetched during a stall, request off
    if_state_e   r_state;
    logic [31:0] r_pc;
    logic [31:0] r_if_inst;
    logic [31:0] r_if_pc4;
    logic        r_if_valid;

    logic        w_req;
    logic        w_xfer;
    logic [31:0] w_pc4;

    assign w_pc4 = pc_plus4(r_pc);

`ifdef IF_SKID_BUFFER_EN
    logic        w_skid_full;
    logic [31:0] w_skid_inst;
    logic [31:0] w_skid_pc4;

    assign w_req = (r_state == IF_RUN) && !bus.Redirect;

    inst_fetch_skid_buffer u_skid (
        .clock   (clock),
        .reset   (reset),
        .i_load  (w_xfer && bus.Stall),
        .i_drain ((r_state == IF_HELD) && !bus.Stall),
        .i_clear (bus.Redirect),
        .i_inst  (bus.IMem_Data),
        .i_pc4   (w_pc4),
        .o_full  (w_skid_full),
        .o_inst  (w_skid_inst),
        .o_pc4   (w_skid_pc4)
    );
`else
    assign w_req = (r_state == IF_RUN) && !bus.Redirect && !bus.Stall;
`endif

    assign w_xfer = w_req && bus.IMem_Ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IF_BOOT;
            r_pc       <= RESET_PC;
            r_if_inst  <= NOP_INST;
            r_if_pc4   <= 32'h0;
            r_if_valid <= 1'b0;
        end else if (bus.Redirect) begin
            r_state    <= IF_RUN;
            r_pc       <= word_align(bus.Redirect_PC);
            r_if_inst  <= NOP_INST;
            r_if_valid <= 1'b0;
        end else begin
            case (r_state)
                IF_BOOT: begin
                    r_state <= IF_RUN;
                    if (!bus.Stall) begin
                        r_if_inst  <= NOP_INST;
                        r_if_valid <= 1'b0;
                    end
                end
                IF_RUN: begin
                    if (w_xfer) r_pc <= w_pc4;
                    if (bus.Stall) begin
`ifdef IF_SKID_BUFFER_EN
                        if (w_xfer) r_state <= IF_HELD;
`endif
                    end else if (w_xfer) begin
                        r_if_inst  <= bus.IMem_Data;
                        r_if_pc4   <= w_pc4;
                        r_if_valid <= 1'b1;
                    end else begin
                        r_if_inst  <= NOP_INST;
                        r_if_valid <= 1'b0;
                    end
                end
`ifdef IF_SKID_BUFFER_EN
                IF_HELD: begin
                    if (!bus.Stall) begin
                        r_state    <= IF_RUN;
                        r_if_inst  <= w_skid_inst;
                        r_if_pc4   <= w_skid_pc4;
                        r_if_valid <= w_skid_full;
                    end
                end
`endif
                default: r_state <= IF_BOOT;
            endcase
        end
    end

    assign bus.IMem_Req    = w_req;
    assign bus.IMem_Addr   = r_pc;
    assign bus.IF_ID_Inst  = r_if_inst;
    assign bus.IF_ID_PC4   = r_if_pc4;
    assign bus.IF_ID_Valid = r_if_valid;
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch; memory returns address-tagged words.
module tb_inst_fetch;
    logic clock = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    inst_fetch_if bus();
    inst_fetch dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;
    assign bus.IMem_Data = bus.IMem_Addr ^ 32'hA500_0000;

`ifdef IF_SKID_BUFFER_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        bus.Stall = 1'b0; bus.Redirect = 1'b0; bus.Redirect_PC = 32'h0; bus.IMem_Ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_cmp++; if (bus.IMem_Req !== 1'b0) begin n_bad++; $display("FAIL rst_req got %b want 0", bus.IMem_Req); end
        n_cmp++; if (bus.IMem_Addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr got %h want 0", bus.IMem_Addr); end
        n_cmp++; if (bus.IF_ID_Inst !== 32'h0) begin n_bad++; $display("FAIL rst_inst got %h want 0", bus.IF_ID_Inst); end
        n_cmp++; if (bus.IF_ID_PC4 !== 32'h0) begin n_bad++; $display("FAIL rst_pc4 got %h want 0", bus.IF_ID_PC4); end
        n_cmp++; if (bus.IF_ID_Valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", bus.IF_ID_Valid); end
        reset = 1'b1;
        #1;
        n_cmp++; if (bus.IMem_Req !== 1'b0) begin n_bad++; $display("FAIL boot_req got %b want 0", bus.IMem_Req); end
    endtask

    task automatic test_stream;
        step;
        n_cmp++; if (bus.IMem_Req !== 1'b1) begin n_bad++; $display("FAIL first_req got %b want 1", bus.IMem_Req); end
        n_cmp++; if (bus.IMem_Addr !== 32'h0) begin n_bad++; $display("FAIL first_addr got %h want 0", bus.IMem_Addr); end
        for (int i = 0; i < 2; i++) begin
            logic [31:0] e_pc4, e_inst;
            e_pc4  = 32'(4 * (i + 1));
            e_inst = 32'(4 * i) ^ 32'hA500_0000;
            step;
            n_cmp++; if (bus.IF_ID_Valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid[%0d] got %b want 1", i, bus.IF_ID_Valid); end
            n_cmp++; if (bus.IF_ID_PC4 !== e_pc4) begin n_bad++; $display("FAIL stream_pc4[%0d] got %h want %h", i, bus.IF_ID_PC4, e_pc4); end
            n_cmp++; if (bus.IF_ID_Inst !== e_inst) begin n_bad++; $display("FAIL stream_inst[%0d] got %h want %h", i, bus.IF_ID_Inst, e_inst); end
            n_cmp++; if (bus.IMem_Addr !== e_pc4) begin n_bad++; $display("FAIL stream_addr[%0d] got %h want %h", i, bus.IMem_Addr, e_pc4); end
        end
    endtask

    task automatic test_wait_states;
        bus.IMem_Ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step;
            n_cmp++; if (bus.IF_ID_Valid !== 1'b0) begin n_bad++; $display("FAIL wait_valid[%0d] got %b want 0", i, bus.IF_ID_Valid); end
            n_cmp++; if (bus.IF_ID_Inst !== 32'h0) begin n_bad++; $display("FAIL wait_inst[%0d] got %h want 0", i, bus.IF_ID_Inst); end
            n_cmp++; if (bus.IF_ID_PC4 !== 32'h8) begin n_bad++; $display("FAIL wait_pc4[%0d] got %h want 8", i, bus.IF_ID_PC4); end
            n_cmp++; if (bus.IMem_Addr !== 32'h8) begin n_bad++; $display("FAIL wait_addr[%0d] got %h want 8", i, bus.IMem_Addr); end
        end
        bus.IMem_Ready = 1'b1;
        step;
        n_cmp++; if (bus.IF_ID_Inst !== 32'hA500_0008) begin n_bad++; $display("FAIL wait_done_inst got %h want a5000008", bus.IF_ID_Inst); end
        n_cmp++; if (bus.IF_ID_PC4 !== 32'hC) begin n_bad++; $display("FAIL wait_done_pc4 got %h want c", bus.IF_ID_PC4); end
        n_cmp++; if (bus.IF_ID_Valid !== 1'b1) begin n_bad++; $display("FAIL wait_done_valid got %b want 1", bus.IF_ID_Valid); end
        step;
        n_cmp++; if (bus.IF_ID_PC4 !== 32'h10) begin n_bad++; $display("FAIL pre_stall_pc4 got %h want 10", bus.IF_ID_PC4); end
    endtask

    task automatic test_stall;
        logic [31:0] e_addr;
        e_addr = SKID ? 32'h14 : 32'h10;
        bus.Stall = 1'b1;
        #1;
        n_cmp++; if (bus.IMem_Req !== SKID) begin n_bad++; $display("FAIL stall_req0 got %b want %b", bus.IMem_Req, SKID); end
        for (int i = 0; i < 2; i++) begin
            step;
            n_cmp++; if (bus.IF_ID_PC4 !== 32'h10) begin n_bad++; $display("FAIL stall_pc4[%0d] got %h want 10", i, bus.IF_ID_PC4); end
            n_cmp++; if (bus.IF_ID_Inst !== 32'hA500_000C) begin n_bad++; $display("FAIL stall_inst[%0d] got %h want a500000c", i, bus.IF_ID_Inst); end
            n_cmp++; if (bus.IF_ID_Valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid[%0d] got %b want 1", i, bus.IF_ID_Valid); end
            n_cmp++; if (bus.IMem_Addr !== e_addr) begin n_bad++; $display("FAIL stall_addr[%0d] got %h want %h", i, bus.IMem_Addr, e_addr); end
            n_cmp++; if (bus.IMem_Req !== 1'b0) begin n_bad++; $display("FAIL stall_req[%0d] got %b want 0", i, bus.IMem_Req); end
        end
        bus.Stall = 1'b0;
        #1;
        n_cmp++; if (bus.IMem_Req !== !SKID) begin n_bad++; $display("FAIL release_req got %b want %b", bus.IMem_Req, !SKID); end
        step;
        n_cmp++; if (bus.IF_ID_PC4 !== 32'h14) begin n_bad++; $display("FAIL release_pc4 got %h want 14", bus.IF_ID_PC4); end
        n_cmp++; if (bus.IF_ID_Inst !== 32'hA500_0010) begin n_bad++; $display("FAIL release_inst got %h want a5000010", bus.IF_ID_Inst); end
        n_cmp++; if (bus.IF_ID_Valid !== 1'b1) begin n_bad++; $display("FAIL release_valid got %b want 1", bus.IF_ID_Valid); end
        n_cmp++; if (bus.IMem_Addr !== 32'h14) begin n_bad++; $display("FAIL release_addr got %h want 14", bus.IMem_Addr); end
        n_cmp++; if (bus.IMem_Req !== 1'b1) begin n_bad++; $display("FAIL resume_req got %b want 1", bus.IMem_Req); end
    endtask

    task automatic test_redirect;
        bus.Stall = 1'b1; bus.Redirect = 1'b1; bus.Redirect_PC = 32'h0000_0103;
        #1;
        n_cmp++; if (bus.IMem_Req !== 1'b0) begin n_bad++; $display("FAIL redir_req got %b want 0", bus.IMem_Req); end
        step;
        bus.Stall = 1'b0; bus.Redirect = 1'b0;
        n_cmp++; if (bus.IMem_Addr !== 32'h100) begin n_bad++; $display("FAIL redir_addr got %h want 100", bus.IMem_Addr); end
        n_cmp++; if (bus.IF_ID_Valid !== 1'b0) begin n_bad++; $display("FAIL redir_valid got %b want 0", bus.IF_ID_Valid); end
        n_cmp++; if (bus.IF_ID_Inst !== 32'h0) begin n_bad++; $display("FAIL redir_inst got %h want 0", bus.IF_ID_Inst); end
        n_cmp++; if (bus.IF_ID_PC4 !== 32'h14) begin n_bad++; $display("FAIL redir_pc4 got %h want 14", bus.IF_ID_PC4); end
        step;
        n_cmp++; if (bus.IF_ID_Inst !== 32'hA500_0100) begin n_bad++; $display("FAIL target_inst got %h want a5000100", bus.IF_ID_Inst); end
        n_cmp++; if (bus.IF_ID_PC4 !== 32'h104) begin n_bad++; $display("FAIL target_pc4 got %h want 104", bus.IF_ID_PC4); end
        n_cmp++; if (bus.IF_ID_Valid !== 1'b1) begin n_bad++; $display("FAIL target_valid got %b want 1", bus.IF_ID_Valid); end
        n_cmp++; if (bus.IMem_Addr !== 32'h104) begin n_bad++; $display("FAIL target_addr got %h want 104", bus.IMem_Addr); end
    endtask

    task automatic test_wrap;
        bus.Redirect = 1'b1; bus.Redirect_PC = 32'hFFFF_FFFC;
        step;
        bus.Redirect = 1'b0;
        n_cmp++; if (bus.IMem_Addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_addr0 got %h want fffffffc", bus.IMem_Addr); end
        step;
        n_cmp++; if (bus.IMem_Addr !== 32'h0) begin n_bad++; $display("FAIL wrap_addr got %h want 0", bus.IMem_Addr); end
        n_cmp++; if (bus.IF_ID_PC4 !== 32'h0) begin n_bad++; $display("FAIL wrap_pc4 got %h want 0", bus.IF_ID_PC4); end
        n_cmp++; if (bus.IF_ID_Inst !== 32'h5AFF_FFFC) begin n_bad++; $display("FAIL wrap_inst got %h want 5afffffc", bus.IF_ID_Inst); end
        n_cmp++; if (bus.IF_ID_Valid !== 1'b1) begin n_bad++; $display("FAIL wrap_valid got %b want 1", bus.IF_ID_Valid); end
    endtask

    task automatic test_reset_mid;
        step; step;
        n_cmp++; if (bus.IMem_Addr !== 32'h8) begin n_bad++; $display("FAIL mid_pre_addr got %h want 8", bus.IMem_Addr); end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.IMem_Addr !== 32'h0) begin n_bad++; $display("FAIL mid_addr got %h want 0", bus.IMem_Addr); end
        n_cmp++; if (bus.IMem_Req !== 1'b0) begin n_bad++; $display("FAIL mid_req got %b want 0", bus.IMem_Req); end
        n_cmp++; if (bus.IF_ID_Inst !== 32'h0) begin n_bad++; $display("FAIL mid_inst got %h want 0", bus.IF_ID_Inst); end
        n_cmp++; if (bus.IF_ID_PC4 !== 32'h0) begin n_bad++; $display("FAIL mid_pc4 got %h want 0", bus.IF_ID_PC4); end
        n_cmp++; if (bus.IF_ID_Valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid got %b want 0", bus.IF_ID_Valid); end
        step;
        reset = 1'b1;
        #1;
        n_cmp++; if (bus.IMem_Req !== 1'b0) begin n_bad++; $display("FAIL reboot_req got %b want 0", bus.IMem_Req); end
        step;
        n_cmp++; if (bus.IMem_Req !== 1'b1) begin n_bad++; $display("FAIL restart_req got %b want 1", bus.IMem_Req); end
        n_cmp++; if (bus.IMem_Addr !== 32'h0) begin n_bad++; $display("FAIL restart_addr got %h want 0", bus.IMem_Addr); end
        step;
        n_cmp++; if (bus.IF_ID_PC4 !== 32'h4) begin n_bad++; $display("FAIL restart_pc4 got %h want 4", bus.IF_ID_PC4); end
        n_cmp++; if (bus.IF_ID_Inst !== 32'hA500_0000) begin n_bad++; $display("FAIL restart_inst got %h want a5000000", bus.IF_ID_Inst); end
        n_cmp++; if (bus.IF_ID_Valid !== 1'b1) begin n_bad++; $display("FAIL restart_valid got %b want 1", bus.IF_ID_Valid); end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_wait_states;
        test_stall;
        test_redirect;
        test_wrap;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
